// File: rtl/pc_ctrl.sv
// Program-counter sequencer: selects the next instruction address from halt/jump/branch
// controls and a loadable branch-target table, and owns the start/done handshake.
module pc_ctrl #(
  parameter int PC_W       = 10,
  parameter int LUT_IDX_W  = 4,
  parameter int START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stall_i,
  input  logic                 halt_i,
  input  logic                 jump_i,
  input  logic                 branch_i,
  input  logic                 eq_i,
  input  logic [LUT_IDX_W-1:0] target_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pc,
  output logic                 running,
  output logic                 done,
  output logic [15:0]          cycles
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  localparam int LUT_N = 1 << LUT_IDX_W;

  state_t          state;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] lut_rdata;
  logic            take;

  // Reads see stored contents only, so a same-edge write is visible one cycle later.
  assign lut_rdata = lut[target_idx];
  assign take      = jump_i | (branch_i & eq_i);

  assign running = (state == RUN);
  assign done    = (state == HALTED);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      cycles <= '0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            state  <= RUN;
            pc     <= PC_W'(START_ADDR);
            cycles <= '0;
          end
        end
        RUN: begin
          if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
          if (!stall_i) begin
            if (halt_i)    state <= HALTED;
            else if (take) pc    <= lut_rdata;
            else           pc    <= pc + PC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the target table is deliberately reset; reset must leave every entry at zero,
  // which rules out a plain RAM macro here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int IDX_W = 4;
  localparam int START = 0;
  localparam int PC_MOD = 1 << PC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stall_i = 1'b0;
  logic             halt_i = 1'b0;
  logic             jump_i = 1'b0;
  logic             branch_i = 1'b0;
  logic             eq_i = 1'b0;
  logic [IDX_W-1:0] target_idx = '0;
  logic             lut_we = 1'b0;
  logic [IDX_W-1:0] lut_waddr = '0;
  logic [PC_W-1:0]  lut_wdata = '0;
  logic [PC_W-1:0]  pc;
  logic             running;
  logic             done;
  logic [15:0]      cycles;

  pc_ctrl #(.PC_W(PC_W), .LUT_IDX_W(IDX_W), .START_ADDR(START)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall_i(stall_i), .halt_i(halt_i),
    .jump_i(jump_i), .branch_i(branch_i), .eq_i(eq_i), .target_idx(target_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .pc(pc), .running(running), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "active" program flag, "finished" flag, integer pc and counter.
  bit m_run, m_done;
  int m_pc, m_cyc;
  int m_lut [1 << IDX_W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pc = 0; m_cyc = 0;
    foreach (m_lut[i]) m_lut[i] = 0;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_pc = START % PC_MOD; m_cyc = 0;
      end
    end else begin
      m_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
      if (!stall_i) begin
        if (halt_i) begin
          m_run = 0; m_done = 1;
        end else if (jump_i || (branch_i && eq_i)) begin
          m_pc = m_lut[target_idx];
        end else begin
          m_pc = (m_pc + 1) % PC_MOD;
        end
      end
    end
    if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic compare();
    check("pc", 32'(pc), 32'(m_pc));
    check("running", 32'(running), 32'(m_run));
    check("done", 32'(done), 32'(m_done));
    check("cycles", 32'(cycles), 32'(m_cyc));
    check("running_done_exclusive", 32'(running & done), 32'd0);
  endtask

  // Inputs change on the falling edge; model advances on the rising edge; outputs compared at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic quiet();
    start = 0; stall_i = 0; halt_i = 0; jump_i = 0; branch_i = 0; eq_i = 0;
    target_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic lut_write(input int idx, input int val);
    lut_we = 1; lut_waddr = IDX_W'(idx); lut_wdata = PC_W'(val);
    step();
    lut_we = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    rst_n = 1;

    // Table loads while IDLE; pc must not move.
    lut_write(3, 'h120);
    lut_write(5, 'h07);
    check("idle_pc_hold", 32'(pc), 32'h0);

    start = 1; step(); start = 0;
    check("start_pc", 32'(pc), 32'h0);
    check("start_running", 32'(running), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_pc", 32'(pc), 32'(i));
    end
    check("seq_cycles", 32'(cycles), 32'd5);

    // Halt, restart, walk to pc=2 for the branch tests.
    halt_i = 1; step(); halt_i = 0;
    check("halt5_pc", 32'(pc), 32'h5);
    start = 1; step(); start = 0;
    step(); step();
    check("pre_branch_pc", 32'(pc), 32'h2);
    branch_i = 1; target_idx = 3; eq_i = 0; step();
    check("branch_not_taken", 32'(pc), 32'h3);
    eq_i = 1; step();
    check("branch_taken", 32'(pc), 32'h120);
    branch_i = 1; eq_i = 0; jump_i = 1; target_idx = 5; step();
    check("jump_priority", 32'(pc), 32'h07);
    quiet();

    stall_i = 1; halt_i = 1;
    repeat (3) step();
    quiet();
    check("stall_pc", 32'(pc), 32'h07);
    check("stall_done", 32'(done), 32'h0);
    check("stall_cycles", 32'(cycles), 32'd8);

    repeat (3) step();
    check("pre_halt_pc", 32'(pc), 32'h0A);
    halt_i = 1; step(); halt_i = 0;
    check("halt_done", 32'(done), 32'h1);
    check("halt_running", 32'(running), 32'h0);
    check("halt_pc", 32'(pc), 32'h0A);
    check("halt_cycles", 32'(cycles), 32'd12);
    repeat (2) step();
    check("halted_hold_pc", 32'(pc), 32'h0A);
    start = 1; step(); start = 0;
    check("restart_pc", 32'(pc), 32'h0);
    check("restart_cycles", 32'(cycles), 32'd0);
    check("restart_done", 32'(done), 32'h0);

    // Wrap and same-cycle write/read of a table entry.
    lut_write(7, 'h3FF);
    jump_i = 1; target_idx = 7; step(); jump_i = 0;
    check("jump_top", 32'(pc), 32'h3FF);
    step();
    check("pc_wrap", 32'(pc), 32'h0);
    jump_i = 1; target_idx = 2; lut_we = 1; lut_waddr = 2; lut_wdata = 'h55; step();
    lut_we = 0;
    check("lut_old_value", 32'(pc), 32'h0);
    step(); jump_i = 0;
    check("lut_new_value", 32'(pc), 32'h55);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom_range(99) < 5);
      stall_i    = ($urandom_range(99) < 15);
      halt_i     = ($urandom_range(99) < 3);
      jump_i     = ($urandom_range(99) < 10);
      branch_i   = ($urandom_range(99) < 20);
      eq_i       = ($urandom_range(99) < 50);
      target_idx = IDX_W'($urandom);
      lut_we     = ($urandom_range(99) < 20);
      lut_waddr  = IDX_W'($urandom);
      lut_wdata  = PC_W'($urandom);
      step();
    end
    quiet();

    // Asynchronous reset mid-RUN clears everything including the table.
    start = 1; step(); start = 0;
    lut_write(4, 'h1AB);
    repeat (3) step();
    #2 rst_n = 0;
    #1 model_reset();
    check("async_rst_pc", 32'(pc), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    check("async_rst_cycles", 32'(cycles), 32'h0);
    @(negedge clk);
    compare();
    rst_n = 1;
    start = 1; step(); start = 0;
    jump_i = 1; target_idx = 4; step(); jump_i = 0;
    check("lut_cleared", 32'(pc), 32'h0);

    // Counter saturation: run past 0xFFFF RUN cycles.
    repeat (65540) step();
    check("cycles_saturate", 32'(cycles), 32'hFFFF);
    check("running_long", 32'(running), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter sequencer for the single-cycle core. Consumes the ALU's `eq` flag together with decoded control bits to select the next instruction address. Resolves conditional and unconditional branches through a small loadable target lookup table, and owns the start/done handshake with the testbench. Sits directly downstream of the ALU and upstream of instruction memory.

## Interface
- `PC_W`, 10, program counter width (instruction memory depth 2^PC_W)
- `LUT_IDX_W`, 4, branch-target table index width; table has 2^LUT_IDX_W entries
- `START_ADDR`, 0, PC loaded on every `start`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin program; honoured in IDLE or HALTED only
- `stall_i`  in  1  hold all state except `lut` writes and `cycles` counter
- `halt_i`  in  1  decoded halt instruction at current `pc`
- `jump_i`  in  1  decoded unconditional branch
- `branch_i`  in  1  decoded conditional branch, taken when `eq_i`=1
- `eq_i`  in  1  ALU equality flag (inA == inB) for current instruction
- `target_idx`  in  LUT_IDX_W  table index for jump/branch
- `lut_we`  in  1  table write enable
- `lut_waddr`  in  LUT_IDX_W  table write index
- `lut_wdata`  in  PC_W  table write data (absolute target)
- `pc`  out  PC_W  registered instruction address
- `running`  out  1  high in RUN
- `done`  out  1  high in HALTED
- `cycles`  out  16  RUN-cycle counter, saturating

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE, `pc`=0, `running`=0, `done`=0, `cycles`=0, all table entries 0.
- IDLE: `start`=1 → RUN, `pc`←START_ADDR, `cycles`←0. Other inputs ignored.
- RUN, per edge, priority order:
  1. `stall_i`=1: `pc` and state hold; halt/jump/branch ignored this cycle.
  2. `halt_i`=1: → HALTED, `pc` holds.
  3. `jump_i`=1: `pc`←`lut[target_idx]`.
  4. `branch_i`=1 and `eq_i`=1: `pc`←`lut[target_idx]`.
  5. Otherwise, including branch not taken: `pc`←`pc`+1, modulo 2^PC_W (wraps 2^PC_W−1 → 0).
- `start` in RUN is ignored.
- HALTED: `done`=1, `pc` holds. `start`=1 → RUN with `pc`←START_ADDR and `cycles`←0.
- `cycles` increments on every edge in RUN, stalled cycles included. Saturates at 0xFFFF. Holds in IDLE/HALTED.
- Table write: `lut[lut_waddr]`←`lut_wdata` on the edge with `lut_we`=1, in any state. Read is combinational from stored contents. Same-cycle write and read of one entry returns the old value; the new value is visible next cycle.
- `running`/`done` decode the state register directly; never both high.

## Timing
- All outputs registered or decoded from registers. No combinational path from inputs to outputs.
- Next-PC decision uses the inputs present in the cycle that `pc` is presented. The result is visible one edge later (latency 1).
- `start` → `running`=1 and `pc`=START_ADDR after 1 edge.
- `halt_i` → `done`=1 after 1 edge. `running` falls on the same edge.
- `rst_n` low asynchronously forces the reset values at any time, including mid-RUN. The table is cleared. Deassertion takes effect from the next rising edge.

## Test plan
- Reset, then `start` pulse with no controls for 5 cycles → `pc` sequence 0,1,2,3,4,5; `running`=1; `cycles`=5.
- Load `lut[3]`=0x120. At `pc`=2 drive `branch_i`=1, `target_idx`=3, `eq_i`=0 → `pc`=3. Repeat with `eq_i`=1 → `pc`=0x120.
- Same edge: `jump_i`=1, `branch_i`=1, `eq_i`=0, `lut[5]`=0x07 via `target_idx`=5 → `pc`=0x07. Then `stall_i`=1 together with `halt_i`=1 for 3 cycles → `pc` holds, `done`=0, `cycles` +3.
- `halt_i` at `pc`=0x0A → next edge `done`=1, `running`=0, `pc`=0x0A. `start` → `pc`=0, `cycles`=0, `done`=0.
- Jump to 0x3FF, no controls → `pc`=0x000 next. Write `lut[2]`=0x55 on the same edge as a jump via index 2 → `pc` takes the old value 0.
- Assert `rst_n`=0 mid-RUN between edges → `pc`=0, IDLE, table cleared immediately. With `cycles` preloaded near 0xFFFF, `cycles` saturates at 0xFFFF.
